fir_sequencer: RTL and testbench

Control front-end for the 3-tap FIR filter core. It owns the core's three control inputs (sample/coefficient bus, sample-valid, set-coefficients) and sequences them. It holds off all traffic during the core's post-reset setup window, loads a complete coefficient set on request, and streams samples between loads. It arbitrates between a coefficient requester and a sample requester, each on a valid/ready interface; coefficient loads have priority.

---
 rtl/fir_pkg.sv | 23 ++
 rtl/fir_seq_counter.sv | 36 +++
 rtl/fir_sequencer.sv | 148 ++++++++++++++
 tb/tb_fir_sequencer.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared state encoding and default sizing for the 3-tap FIR core and its sequencer.
// Counter widths are derived here so every instance sizes itself from the same rule.
package fir_pkg;

  localparam int X_N_SIZE_DEF     = 8;
  localparam int TAP_SIZE_DEF     = 6;
  localparam int NBR_OF_TAPS_DEF  = 3;
  localparam int SETUP_CYCLES_DEF = 4;
  localparam int IDLE_TIMEOUT_DEF = 8;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_LOAD   = 3'd2,
    ST_GAP    = 3'd3,
    ST_STREAM = 3'd4
  } fir_state_e;

  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/fir_seq_counter.sv
// Loadable saturating down-counter; zero_o flags that the count is 0 after this cycle,
// so a caller can act on the same edge at which the counter reaches zero.
module fir_seq_counter #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_d == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= RESET_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fir_sequencer.sv
// Control front-end for the 3-tap FIR core: holds off traffic after reset, loads coefficient
// sets (priority) and streams samples, guaranteeing a dead cycle between the two modes.
module fir_sequencer
  import fir_pkg::*;
#(
  parameter int X_N_SIZE     = X_N_SIZE_DEF,
  parameter int TAP_SIZE     = TAP_SIZE_DEF,
  parameter int NBR_OF_TAPS  = NBR_OF_TAPS_DEF,
  parameter int SETUP_CYCLES = SETUP_CYCLES_DEF,
  parameter int IDLE_TIMEOUT = IDLE_TIMEOUT_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cfg_start,
  input  logic                       cfg_valid,
  input  logic signed [TAP_SIZE-1:0] cfg_data,
  output logic                       cfg_ready,
  input  logic                       smp_valid,
  input  logic signed [X_N_SIZE-1:0] smp_data,
  output logic                       smp_ready,
  output logic        [X_N_SIZE-1:0] fir_x_n,
  output logic                       fir_tvalid,
  output logic                       fir_set_coeffs,
  output logic                       busy,
  output logic                       cfg_done
);

  localparam int SETUP_W  = cnt_width(SETUP_CYCLES);
  localparam int TAP_W    = cnt_width(NBR_OF_TAPS);
  localparam int STARVE_W = cnt_width(IDLE_TIMEOUT);

  fir_state_e          state_q, state_d;
  logic                pend_q, pend_d;
  logic [X_N_SIZE-1:0] x_n_q, x_n_d;
  logic                tvalid_q, tvalid_d;
  logic                set_q, set_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                cfg_acc, smp_acc;
  logic                setup_zero, tap_zero, starve_zero;

  assign cfg_ready = (state_q == ST_LOAD);
  assign smp_ready = (state_q == ST_STREAM) && !cfg_start && !pend_q;
  assign cfg_acc   = cfg_valid && cfg_ready;
  assign smp_acc   = smp_valid && smp_ready;

  fir_seq_counter #(.WIDTH(SETUP_W), .RESET_VAL(SETUP_W'(SETUP_CYCLES))) u_setup_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (1'b0),
    .load_val_i (SETUP_W'(SETUP_CYCLES)),
    .dec_i      (state_q == ST_INIT),
    .zero_o     (setup_zero)
  );

  // Re-armed whenever we are outside LOAD, so every load needs a full set of beats.
  fir_seq_counter #(.WIDTH(TAP_W), .RESET_VAL(TAP_W'(NBR_OF_TAPS))) u_tap_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (state_q != ST_LOAD),
    .load_val_i (TAP_W'(NBR_OF_TAPS)),
    .dec_i      (cfg_acc),
    .zero_o     (tap_zero)
  );

  fir_seq_counter #(.WIDTH(STARVE_W), .RESET_VAL(STARVE_W'(IDLE_TIMEOUT))) u_starve_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     ((state_q != ST_STREAM) || smp_acc),
    .load_val_i (STARVE_W'(IDLE_TIMEOUT)),
    .dec_i      ((state_q == ST_STREAM) && !smp_acc && !cfg_start),
    .zero_o     (starve_zero)
  );

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    x_n_d    = x_n_q;
    tvalid_d = 1'b0;
    set_d    = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (setup_zero) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (cfg_start) state_d = ST_LOAD;
        else if (smp_valid) state_d = ST_STREAM;
      end
      ST_LOAD: begin
        if (cfg_acc) begin
          x_n_d = X_N_SIZE'(cfg_data);
          set_d = 1'b1;
          if (tap_zero) begin
            done_d  = 1'b1;
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        state_d = pend_q ? ST_LOAD : ST_IDLE;
      end
      ST_STREAM: begin
        if (smp_acc) begin
          x_n_d    = smp_data;
          tvalid_d = 1'b1;
        end
        // A config request preempts streaming via one dead cycle in GAP.
        if (cfg_start) begin
          pend_d  = 1'b1;
          state_d = ST_GAP;
        end else if (starve_zero) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_INIT;
    endcase
    if (state_d == ST_LOAD) pend_d = 1'b0;
    busy_d = (state_d == ST_INIT) || (state_d == ST_LOAD) || (state_d == ST_GAP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_INIT;
      pend_q   <= 1'b0;
      x_n_q    <= '0;
      tvalid_q <= 1'b0;
      set_q    <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      x_n_q    <= x_n_d;
      tvalid_q <= tvalid_d;
      set_q    <= set_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign fir_x_n        = x_n_q;
  assign fir_tvalid     = tvalid_q;
  assign fir_set_coeffs = set_q;
  assign cfg_done       = done_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_fir_sequencer.sv
// Cycle-by-cycle vector table for fir_sequencer, plus a reset-during-load sequence.
module tb_fir_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_start, cfg_valid, smp_valid;
  logic [5:0] cfg_data;
  logic [7:0] smp_data;
  logic       cfg_ready, smp_ready, fir_tvalid, fir_set_coeffs, busy, cfg_done;
  logic [7:0] fir_x_n;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        cs, cv;
    logic [5:0]  cd;
    logic        sv;
    logic [7:0]  sd;
    logic [13:0] exp_o;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  fir_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .cfg_start      (cfg_start),
    .cfg_valid      (cfg_valid),
    .cfg_data       (cfg_data),
    .cfg_ready      (cfg_ready),
    .smp_valid      (smp_valid),
    .smp_data       (smp_data),
    .smp_ready      (smp_ready),
    .fir_x_n        (fir_x_n),
    .fir_tvalid     (fir_tvalid),
    .fir_set_coeffs (fir_set_coeffs),
    .busy           (busy),
    .cfg_done       (cfg_done)
  );

  // Packed observation order: cfg_ready, smp_ready, fir_x_n, fir_tvalid, fir_set_coeffs, cfg_done, busy
  function automatic logic [13:0] pack(input logic cr, input logic sr, input logic [7:0] x,
                                       input logic tv, input logic sc, input logic dn,
                                       input logic bz);
    return {cr, sr, x, tv, sc, dn, bz};
  endfunction

  function automatic logic [13:0] dut_o();
    return {cfg_ready, smp_ready, fir_x_n, fir_tvalid, fir_set_coeffs, cfg_done, busy};
  endfunction

  task automatic add(input logic cs, input logic cv, input logic [5:0] cd, input logic sv,
                     input logic [7:0] sd, input logic cr, input logic sr, input logic [7:0] x,
                     input logic tv, input logic sc, input logic dn, input logic bz);
    vec_t v;
    v.cs = cs; v.cv = cv; v.cd = cd; v.sv = sv; v.sd = sd;
    v.exp_o = pack(cr, sr, x, tv, sc, dn, bz);
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, sc_cnt, done_cnt;

    // cs cv cd sv sd | cr sr x tv sc dn busy
    for (int i = 0; i < 4; i++) add(1, 0, 6'h00, 1, 8'h00, 0, 0, 8'h00, 0, 0, 0, 1); // INIT
    add(1, 0, 6'h00, 1, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0); // IDLE, load beats stream
    add(0, 1, 6'h05, 1, 8'h00, 1, 0, 8'h00, 0, 0, 0, 1); // LOAD, first ready
    add(0, 1, 6'h3f, 1, 8'h00, 1, 0, 8'h05, 0, 1, 0, 1);
    add(0, 1, 6'h00, 0, 8'h00, 1, 0, 8'hff, 0, 1, 0, 1);
    add(0, 0, 6'h00, 0, 8'h00, 0, 0, 8'h00, 0, 1, 1, 1); // GAP, done
    add(1, 0, 6'h00, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0); // IDLE
    add(0, 1, 6'h01, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 1); // LOAD with valid gap
    add(0, 1, 6'h02, 0, 8'h00, 1, 0, 8'h01, 0, 1, 0, 1);
    add(0, 0, 6'h3e, 0, 8'h00, 1, 0, 8'h02, 0, 1, 0, 1);
    add(0, 1, 6'h20, 0, 8'h00, 1, 0, 8'h02, 0, 0, 0, 1);
    add(0, 0, 6'h00, 0, 8'h00, 0, 0, 8'he0, 0, 1, 1, 1); // GAP
    add(0, 0, 6'h00, 1, 8'h01, 0, 0, 8'he0, 0, 0, 0, 0); // IDLE
    add(0, 0, 6'h00, 1, 8'h01, 0, 1, 8'he0, 0, 0, 0, 0); // STREAM
    add(0, 0, 6'h00, 1, 8'h02, 0, 1, 8'h01, 1, 0, 0, 0);
    add(0, 0, 6'h00, 1, 8'h03, 0, 1, 8'h02, 1, 0, 0, 0);
    add(0, 0, 6'h00, 0, 8'h00, 0, 1, 8'h03, 1, 0, 0, 0); // starve 1
    for (int i = 0; i < 7; i++) add(0, 0, 6'h00, 0, 8'h00, 0, 1, 8'h03, 0, 0, 0, 0);
    add(0, 0, 6'h00, 1, 8'h40, 0, 0, 8'h03, 0, 0, 0, 0); // IDLE after timeout
    add(0, 0, 6'h00, 1, 8'h40, 0, 1, 8'h03, 0, 0, 0, 0); // STREAM
    add(1, 0, 6'h00, 1, 8'h41, 0, 0, 8'h40, 1, 0, 0, 0); // cfg_start drops smp_ready
    add(0, 0, 6'h00, 1, 8'h41, 0, 0, 8'h40, 0, 0, 0, 1); // GAP
    add(0, 1, 6'h07, 0, 8'h00, 1, 0, 8'h40, 0, 0, 0, 1); // LOAD
    add(0, 1, 6'h09, 0, 8'h00, 1, 0, 8'h07, 0, 1, 0, 1);
    add(0, 0, 6'h00, 0, 8'h00, 1, 0, 8'h09, 0, 1, 0, 1); // two of three loaded

    reset = 1'b1; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
    smp_valid = 1'b0; smp_data = '0;
    repeat (3) @(posedge clk);
    #2;
    check("reset_state", 32'(dut_o()), 32'(pack(0, 0, 8'h00, 0, 0, 0, 1)));
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      cfg_start = vecs[i].cs; cfg_valid = vecs[i].cv; cfg_data = vecs[i].cd;
      smp_valid = vecs[i].sv; smp_data = vecs[i].sd;
      #1;
      check($sformatf("row%0d", i), 32'(dut_o()), 32'(vecs[i].exp_o));
      @(posedge clk);
      #2;
    end

    // Reset with a partial load in flight, then prove the next load needs all three beats.
    reset = 1'b1; cfg_start = 1'b0; cfg_valid = 1'b0; smp_valid = 1'b0;
    @(posedge clk);
    #2;
    check("reset_mid_load", 32'(dut_o()), 32'(pack(0, 0, 8'h00, 0, 0, 0, 1)));
    reset = 1'b0; cfg_start = 1'b1;
    #1;
    n = 0;
    while (!cfg_ready && n < 20) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("first_ready_cycle", 32'(n), 32'd5);

    cfg_start = 1'b0; cfg_valid = 1'b1; cfg_data = 6'h11;
    sc_cnt = 0; done_cnt = 0;
    for (int j = 0; j < 6; j++) begin
      @(posedge clk);
      #2;
      if (j == 0) cfg_data = 6'h12;
      else if (j == 1) cfg_data = 6'h13;
      else cfg_valid = 1'b0;
      #1;
      if (j == 1) check("ready_after_two_beats", 32'(cfg_ready), 32'd1);
      if (fir_set_coeffs) sc_cnt++;
      if (cfg_done) begin
        done_cnt++;
        check("done_data", 32'(fir_x_n), 32'h13);
      end
    end
    check("set_coeffs_pulses", 32'(sc_cnt), 32'd3);
    check("cfg_done_pulses", 32'(done_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
